// File: rtl/rvj1_ifu.sv
// rvj1_ifu: word-aligned instruction fetch with an in-order response FIFO and redirect flush.
// Optional feature macro RVJ1_IFU_PC_OUT_EN adds instr_addr_o (PC of instr_o) via an in-flight address queue.
module rvj1_ifu #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [31:0] jmp_addr_i,
  input  logic        jmp_addr_valid_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i
`ifdef RVJ1_IFU_PC_OUT_EN
  ,
  output logic [31:0] instr_addr_o
`endif
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
`ifdef RVJ1_IFU_PC_OUT_EN
  localparam int unsigned EW = 64;
`else
  localparam int unsigned EW = 32;
`endif

  typedef enum logic {ST_BOOT, ST_RUN} state_t;

  state_t        r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_stale_addr;
  logic          r_pend;
  logic          r_stale;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_disc;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [EW-1:0] r_fifo [FIFO_DEPTH];

  logic          w_req;
  logic          w_gnt;
  logic          w_pend_nxt;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;
  logic [CW:0]   w_occ;
  logic [CW-1:0] w_out_nxt;
  logic [31:0]   w_addr;
  logic [EW-1:0] w_entry;
  logic [1:0]    w_unused_jmp_lsb;

  assign w_unused_jmp_lsb = jmp_addr_i[1:0];

  assign w_occ      = {1'b0, r_count} + {1'b0, r_out};
  assign w_req      = (r_state == ST_RUN) && (r_pend || (w_occ < DEPTH_W));
  // A request left pending across a redirect keeps its pre-redirect address.
  assign w_addr     = r_stale ? r_stale_addr : r_pc;
  assign w_gnt      = w_req && mem_gnt_i;
  assign w_pend_nxt = w_req && !mem_gnt_i;
  assign w_out_nxt  = r_out + CW'(w_gnt) - CW'(mem_rvalid_i);

  assign w_valid = (r_count != '0);
  assign w_drop  = mem_rvalid_i && ((r_disc != '0) || jmp_addr_valid_i);
  assign w_push  = mem_rvalid_i && !w_drop;
  assign w_pop   = w_valid && instr_ready_i && !jmp_addr_valid_i;

  assign mem_req_o     = w_req;
  assign mem_addr_o    = w_addr;
  assign instr_valid_o = w_valid;
  assign instr_o       = w_valid ? r_fifo[r_rd_ptr][31:0] : '0;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state      <= ST_BOOT;
      r_pc         <= BOOT_ADDR;
      r_stale_addr <= BOOT_ADDR;
      r_pend       <= 1'b0;
      r_stale      <= 1'b0;
      r_out        <= '0;
      r_disc       <= '0;
    end else begin
      if (r_state == ST_BOOT) r_state <= ST_RUN;
      r_pend <= w_pend_nxt;
      r_out  <= w_out_nxt;
      if (jmp_addr_valid_i) begin
        // Everything still owed by memory, including an ungranted request, is stale.
        r_pc         <= {jmp_addr_i[31:2], 2'b00};
        r_disc       <= w_out_nxt + CW'(w_pend_nxt);
        r_stale      <= w_pend_nxt;
        r_stale_addr <= w_addr;
      end else begin
        if (w_gnt) begin
          if (r_stale) r_stale <= 1'b0;
          else         r_pc    <= r_pc + 32'd4;
        end
        if (w_drop) r_disc <= r_disc - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (jmp_addr_valid_i) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_entry;
  end

`ifdef RVJ1_IFU_PC_OUT_EN
  logic [31:0]   r_aq [FIFO_DEPTH];
  logic [AW-1:0] r_aq_rd;
  logic [AW-1:0] r_aq_wr;

  // The address queue is never flushed: stale responses still retire their entry.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_aq_rd <= '0;
      r_aq_wr <= '0;
    end else begin
      if (w_gnt)        r_aq_wr <= r_aq_wr + AW'(1);
      if (mem_rvalid_i) r_aq_rd <= r_aq_rd + AW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_gnt) r_aq[r_aq_wr] <= w_addr;
  end

  assign w_entry      = {r_aq[r_aq_rd], mem_rdata_i};
  assign instr_addr_o = w_valid ? r_fifo[r_rd_ptr][63:32] : '0;
`else
  assign w_entry = mem_rdata_i;
`endif

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(w_push && !w_pop && (r_count == DEPTH_C)));
  a_no_spurious_rvalid: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(mem_rvalid_i && (r_out == '0)));
  a_out_bounded: assert property (@(posedge clk_i) disable iff (!rstn_i)
    (r_out <= DEPTH_C));

endmodule

// File: tb/tb_rvj1_ifu.sv
// Directed + randomized bench for rvj1_ifu: memory responder with in-order latency queue and
// an instruction-stream scoreboard (expected stream = mem words from the last redirect target).
module tb_rvj1_ifu;

  localparam logic [31:0] BOOT  = 32'h0000_0000;
  localparam int unsigned DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [31:0] jmp_addr_i;
  logic        jmp_addr_valid_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
`ifdef RVJ1_IFU_PC_OUT_EN
  logic [31:0] instr_addr_o;
`endif

  rvj1_ifu #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .jmp_addr_i(jmp_addr_i), .jmp_addr_valid_i(jmp_addr_valid_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .instr_o(instr_o), .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i)
`ifdef RVJ1_IFU_PC_OUT_EN
    , .instr_addr_o(instr_addr_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {logic [31:0] addr; int unsigned due;} rsp_t;
  rsp_t q[$];

  int unsigned n_checks = 0, n_err = 0;
  int unsigned cyc = 0, n_gnt = 0, n_deliv = 0;
  int unsigned gnt_mode = 1, lat = 1;
  bit          rand_lat = 0, ready = 0, jmp_req = 0, ok;
  logic [31:0] jmp_tgt = '0, exp_pc = BOOT, a0;
  bit          p_hold = 0, p_req_wait = 0, p_jmp = 0;
  logic [31:0] p_instr = '0, p_addr = '0;
  int unsigned d0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    if (a == 32'h4) return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs and check stable outputs at negedge, return #1 after posedge.
  task automatic tick();
    bit g;
    int unsigned l;
    @(negedge clk_i);
    if (p_hold) begin
      chk("instr_hold", instr_o, p_instr);
      chk("valid_hold", 32'(instr_valid_o), 1);
    end
    if (p_req_wait) begin
      chk("req_hold", 32'(mem_req_o), 1);
      chk("addr_hold", mem_addr_o, p_addr);
    end
    if (p_jmp) chk("valid_after_jmp", 32'(instr_valid_o), 0);
    if (mem_req_o) chk("addr_align", 32'(mem_addr_o[1:0]), 0);
    case (gnt_mode)
      0:       g = 1'b0;
      1:       g = 1'b1;
      default: g = ($urandom_range(0, 1) == 1);
    endcase
    mem_gnt_i = g;
    if (q.size() > 0 && q[0].due <= cyc) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mem_word(q[0].addr);
      void'(q.pop_front());
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = $urandom;
    end
    if (mem_req_o && g) begin
      l = rand_lat ? $urandom_range(1, 3) : lat;
      q.push_back('{addr: mem_addr_o, due: cyc + l});
      n_gnt++;
    end
    chk("inflight_bound", 32'(q.size() <= DEPTH), 1);
    jmp_addr_valid_i = jmp_req;
    jmp_addr_i       = jmp_tgt;
    instr_ready_i    = ready;
    if (instr_valid_o && ready && !jmp_req) begin
      chk("instr", instr_o, mem_word(exp_pc));
`ifdef RVJ1_IFU_PC_OUT_EN
      chk("instr_addr", instr_addr_o, exp_pc);
`endif
      exp_pc = exp_pc + 32'd4;
      n_deliv++;
    end
    if (jmp_req) exp_pc = {jmp_tgt[31:2], 2'b00};
    p_hold     = instr_valid_o && !ready && !jmp_req;
    p_instr    = instr_o;
    p_req_wait = mem_req_o && !g;
    p_addr     = mem_addr_o;
    p_jmp      = jmp_req;
    jmp_req    = 1'b0;
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic clear_model();
    q.delete();
    exp_pc = BOOT; p_hold = 0; p_req_wait = 0; p_jmp = 0; jmp_req = 0;
    jmp_addr_valid_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0; jmp_addr_i = '0;
    instr_ready_i = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(mem_req_o), 0);
    chk({tag, "_addr"}, mem_addr_o, BOOT);
    chk({tag, "_instr"}, instr_o, 32'h0);
    chk({tag, "_valid"}, 32'(instr_valid_o), 0);
`ifdef RVJ1_IFU_PC_OUT_EN
    chk({tag, "_iaddr"}, instr_addr_o, 32'h0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn_i = 1'b0;
    clear_model();
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_outputs("reset");
    rstn_i = 1'b1;
    chk("boot_no_req", 32'(mem_req_o), 0);

    // Startup with decoder stalled: addresses 0,4,8 then exactly DEPTH grants.
    gnt_mode = 1; lat = 1; ready = 0;
    tick();
    chk("first_req", 32'(mem_req_o), 1);
    chk("first_addr", mem_addr_o, BOOT);
    tick();
    chk("second_addr", mem_addr_o, BOOT + 32'd4);
    tick();
    chk("third_addr", mem_addr_o, BOOT + 32'd8);
    repeat (17) tick();
    chk("stall_grants", n_gnt, DEPTH);
    chk("stall_req_off", 32'(mem_req_o), 0);
    chk("stall_valid", 32'(instr_valid_o), 1);
    chk("stall_head", instr_o, mem_word(BOOT));
    ready = 1;
    repeat (12) tick();
    chk("drain_all", 32'(n_deliv >= DEPTH + 2), 1);

    // Latency 3, redirect with two responses outstanding.
    lat = 3;
    repeat (4) tick();
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (q.size() == 2) begin ok = 1; break; end
      tick();
    end
    chk("wait_two_inflight", 32'(ok), 1);
    jmp_req = 1; jmp_tgt = 32'h0000_0103;
    tick();
    chk("redir_next_addr", mem_addr_o, 32'h0000_0100);
    d0 = n_deliv;
    repeat (15) tick();
    chk("redir_progress", 32'(n_deliv > d0), 1);

    // Redirect to 0x200 at latency 1.
    lat = 1;
    jmp_req = 1; jmp_tgt = 32'h0000_0200;
    tick();
    d0 = n_deliv;
    repeat (10) tick();
    chk("j200_progress", 32'(n_deliv >= d0 + 3), 1);

    // Grant stall with a redirect landing on the pending request.
    gnt_mode = 0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req_o) begin ok = 1; break; end
      tick();
    end
    chk("stall_req_seen", 32'(ok), 1);
    a0 = mem_addr_o;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("gstall_req", 32'(mem_req_o), 1);
      chk("gstall_addr", mem_addr_o, a0);
    end
    jmp_req = 1; jmp_tgt = 32'h0000_0300;
    tick();
    chk("stale_addr_kept", mem_addr_o, a0);
    tick();
    chk("stale_addr_kept2", mem_addr_o, a0);
    gnt_mode = 1;
    tick();
    chk("post_stale_addr", mem_addr_o, 32'h0000_0300);
    d0 = n_deliv;
    repeat (12) tick();
    chk("post_stale_progress", 32'(n_deliv > d0), 1);

    // PC wrap at the top of the address space.
    jmp_req = 1; jmp_tgt = 32'hFFFF_FFF9;
    tick();
    d0 = n_deliv;
    repeat (10) tick();
    chk("wrap_progress", 32'(n_deliv >= d0 + 4), 1);

    // Randomized traffic.
    gnt_mode = 2; rand_lat = 1;
    d0 = n_deliv;
    for (int i = 0; i < 400; i++) begin
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) begin
        jmp_req = 1; jmp_tgt = $urandom;
      end
      tick();
    end
    chk("random_progress", 32'(n_deliv > d0 + 20), 1);

    // Asynchronous reset mid-burst.
    gnt_mode = 1; rand_lat = 0; lat = 3; ready = 0;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (q.size() >= 2 && instr_valid_o) begin ok = 1; break; end
      tick();
    end
    chk("burst_reached", 32'(ok), 1);
    #2 rstn_i = 1'b0;
    #1;
    check_reset_outputs("async");
    clear_model();
    n_gnt = 0;
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    chk("reboot_no_req", 32'(mem_req_o), 0);
    lat = 1; ready = 1;
    tick();
    chk("reboot_addr", mem_addr_o, BOOT);
    d0 = n_deliv;
    repeat (12) tick();
    chk("reboot_progress", 32'(n_deliv >= d0 + 4), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
